// File: rtl/des_key_schedule_seq.sv
// Purpose: DES subkey sequencer; loads a key and streams K1..K16 (or K16..K1) one per handshake.
// Latency: first subkey valid 1 cycle after START; one subkey per cycle while SUBKEY_READY is high.
// Backpressure: SUBKEY/ROUND hold while SUBKEY_READY=0; START ignored whenever BUSY.
//
// Ports:
//   CLK, RESET_BAR          rising-edge clock, asynchronous active-low reset
//   START, DECRYPT, KEY     load request (sampled in IDLE only), order select, FIPS key [64:1]
//   SUBKEY, SUBKEY_VALID,   current 48-bit subkey [48:1] and its valid/ready handshake
//   SUBKEY_READY
//   ROUND, LAST             subkey index (0 = K1), marker for the 16th subkey of the stream
//   BUSY, DONE              not-idle flag, one-cycle pulse after the 16th handshake
module des_key_schedule_seq (
  input  logic        CLK,
  input  logic        RESET_BAR,
  input  logic        START,
  input  logic        DECRYPT,
  input  logic [64:1] KEY,
  output logic [48:1] SUBKEY,
  output logic        SUBKEY_VALID,
  input  logic        SUBKEY_READY,
  output logic [4:1]  ROUND,
  output logic        LAST,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE_ST = 2'd2} state_t;

  // FIPS 46-3 permuted choice tables, entries are 1-based FIPS bit numbers.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // C and D keep FIPS bit 1 in the MSB, so FIPS bit n of {c,d} sits at index 56-n.
  function automatic logic [55:0] pc1_map(input logic [64:1] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[65-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_map(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  function automatic logic [27:0] rot_left(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rot_right(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // shift[k] for k = 1..16 is 1 at rounds 1, 2, 9, 16 and 2 elsewhere.
  function automatic logic shift_is_two(input logic [4:0] k);
    return !((k == 5'd1) || (k == 5'd2) || (k == 5'd9) || (k == 5'd16));
  endfunction

  state_t      state, state_nxt;
  logic [27:0] c, d;
  logic [3:0]  step;
  logic        mode;
  logic [55:0] key_cd;
  logic        load, hs, adv;
  logic        enc_two, dec_two;

  assign key_cd  = pc1_map(KEY);
  assign load    = (state == IDLE) && START;
  assign hs      = (state == RUN) && SUBKEY_READY;
  assign adv     = hs && (step != 4'd15);
  // Encryption walks forward to shift[step+2]; decryption unwinds shift[16-step].
  assign enc_two = shift_is_two({1'b0, step} + 5'd2);
  assign dec_two = shift_is_two(5'd16 - {1'b0, step});

  // State register
  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (hs && (step == 4'd15)) state_nxt = DONE_ST;
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    SUBKEY_VALID = (state == RUN);
    BUSY         = (state != IDLE);
    DONE         = (state == DONE_ST);
    LAST         = (state == RUN) && (step == 4'd15);
    ROUND        = '0;
    if (state == RUN) ROUND = mode ? (4'd15 - step) : step;
  end

  // Key halves and step counter. Encryption pre-rotates by shift[1] at load so K1
  // is presented first; decryption starts from C16 = C0 without any rotation.
  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      c    <= '0;
      d    <= '0;
      step <= '0;
      mode <= 1'b0;
    end else if (load) begin
      c    <= DECRYPT ? key_cd[55:28] : rot_left(key_cd[55:28], 1'b0);
      d    <= DECRYPT ? key_cd[27:0]  : rot_left(key_cd[27:0], 1'b0);
      step <= '0;
      mode <= DECRYPT;
    end else if (adv) begin
      step <= step + 4'd1;
      if (mode) begin
        c <= rot_right(c, dec_two);
        d <= rot_right(d, dec_two);
      end else begin
        c <= rot_left(c, enc_two);
        d <= rot_left(d, enc_two);
      end
    end
  end

  assign SUBKEY = pc2_map({c, d});

endmodule

// File: doc/des_key_schedule_seq.md
Name: des_key_schedule_seq

Overview:
- Sequential DES subkey sequencer. Loads a 64-bit key and streams the 16 48-bit round subkeys one per handshake over a valid/ready interface.
- DECRYPT=1 gives decryption order (K16..K1, right rotations). DECRYPT=0 gives encryption order (K1..K16, left rotations).
- Feeds an iterative single-round DES datapath that cannot hold all 16 subkeys in parallel.

Parameters:
- none (DES widths fixed: KEY 64, C/D halves 28, subkey 48).

Ports:
- CLK  input  1  rising-edge clock.
- RESET_BAR  input  1  asynchronous active-low reset.
- START  input  1  load request, sampled only in IDLE.
- DECRYPT  input  1  subkey order select, sampled with START.
- KEY  input  64  [64:1]. FIPS bit n maps to KEY[65-n], so KEY[64] is the leftmost FIPS bit. FIPS bits 8,16,..,64 are parity and ignored.
- SUBKEY  output  48  [48:1]. FIPS subkey bit n maps to SUBKEY[49-n].
- SUBKEY_VALID  output  1  SUBKEY and ROUND are valid.
- SUBKEY_READY  input  1  consumer accepts the current subkey.
- ROUND  output  4  [4:1]. Index of the current subkey, 0 = K1 .. 15 = K16.
- LAST  output  1  current subkey is the 16th of the stream.
- BUSY  output  1  high whenever the FSM is not IDLE.
- DONE  output  1  one-cycle pulse after the 16th handshake.

Behaviour:
- Reset (asynchronous, RESET_BAR=0):
  - FSM goes to IDLE.
  - C, D, step counter, SUBKEY, ROUND, SUBKEY_VALID, LAST, BUSY and DONE all go to 0.
  - Reset may assert mid-stream. The stream is abandoned; no DONE is produced.
- State IDLE:
  - SUBKEY_VALID=0, BUSY=0.
  - START=1 at edge t: C,D <= PC1(KEY), step <= 0, mode <= DECRYPT, go to RUN.
  - If DECRYPT=0, the loaded C,D are additionally rotated left by 1, so K1 is ready.
  - If DECRYPT=1, no rotation is applied (C16 = C0), so K16 is ready.
- State RUN:
  - SUBKEY_VALID=1 from cycle t+1, so first-subkey latency is 1 cycle after START.
  - SUBKEY = PC2(C,D), combinational from the C/D registers only. SUBKEY and ROUND stay stable while SUBKEY_READY=0.
  - ROUND = step when mode=0; ROUND = 15-step when mode=1.
  - LAST = (step==15).
  - A handshake is SUBKEY_VALID & SUBKEY_READY at a clock edge.
  - On a handshake with step<15: step++, and C,D are rotated by the next amount:
    - encryption: left, amount = shift[step+2];
    - decryption: right, amount = shift[16-step].
  - shift[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Resulting decryption right-rotation sequence after outputs 1..15: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - On a handshake with step==15: go to DONE_ST. SUBKEY_VALID drops on the next cycle.
- State DONE_ST:
  - Lasts exactly one cycle. DONE=1, BUSY=1, SUBKEY_VALID=0.
  - Then returns to IDLE.
  - A START arriving during DONE_ST is ignored.
- START while BUSY: ignored. KEY and DECRYPT changes are also ignored until IDLE.
- Back-to-back streams: START is accepted on the first IDLE cycle after DONE. Minimum stream period is 18 cycles with READY held high.
- Rotations are 28-bit circular within C and within D independently. A rotation never crosses between C and D.
- PC1 and PC2 are the FIPS 46-3 tables, implemented as pure wiring.

Test Plan:
- Encryption order, KEY=64'h133457799BBCDFF1, DECRYPT=0, READY held 1:
  - SUBKEY_VALID rises 1 cycle after START, with ROUND=0 and SUBKEY=48'h1B02EFFC7072.
  - The 16th subkey is 48'hCB3D8B0E17F5 with LAST=1.
  - DONE pulses on the following cycle, and BUSY falls the cycle after that.
- Decryption order, same key, DECRYPT=1:
  - First subkey is 48'hCB3D8B0E17F5 with ROUND=15.
  - Last subkey is 48'h1B02EFFC7072 with ROUND=0.
  - The full sequence equals the encryption sequence reversed; compare all 16 against a reference model.
- Backpressure:
  - Random READY, 30% high. Each subkey appears exactly once, in order.
  - SUBKEY and ROUND stay constant for every cycle with VALID=1 and READY=0.
  - Total handshakes = 16.
- START while busy:
  - Pulse START with a different KEY at step 5. The stream continues unchanged with the original key.
  - A second START issued on the first IDLE cycle after DONE loads the new key, and its VALID rises 1 cycle later.
- Reset mid-stream:
  - Assert RESET_BAR=0 asynchronously at step 7, between clock edges. All outputs go to 0 immediately and no DONE is produced.
  - A fresh START after release restarts at ROUND=0 with the correct K1.
- Parity insensitivity: KEY=64'h123456789ABCDEF0 versus the same key with all parity bits inverted gives identical 16-subkey streams.
